// File: rtl/cla_pkg.sv
// Shared ALU constants: datapath width and status-register flag positions.
package cla_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    // Flag bit positions inside the ALU status register
    localparam int unsigned FLAG_CARRY    = 0;
    localparam int unsigned FLAG_OVERFLOW = 1;
    localparam int unsigned FLAG_ZERO     = 2;
    localparam int unsigned FLAG_NEGATIVE = 3;
    localparam int unsigned FLAG_W        = 4;

    localparam int unsigned GROUP_W = 4;

endpackage

// File: rtl/cla_cla4.sv
// 4-bit carry-lookahead slice: sum bits plus group generate/propagate.
module cla_cla4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               g_grp,
    output logic               p_grp
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] c;

    // Bit-level G/P, flattened internal carries, sum and group G/P
    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        s = p ^ c;

        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        p_grp = &p;
    end

endmodule

// File: rtl/cla.sv
// Two-level carry-lookahead adder with ALU condition flags; optional output register.
// WIDTH must be a multiple of 4.
module cla
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH      = DATA_WIDTH,
    parameter int unsigned REGISTERED = 0
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iX,
    input  logic [WIDTH-1:0] iY,
    input  logic             iCarry,
    output logic [WIDTH-1:0] oS,
    output logic             oCarry,
    output logic             oOverflow,
    output logic             oZero,
    output logic             oNegative
);

    localparam int unsigned NG = WIDTH / GROUP_W;

    logic [NG-1:0]     grp_g;
    logic [NG-1:0]     grp_p;
    logic [NG:0]       grp_c;
    logic [WIDTH-1:0]  sum_d;
    logic [WIDTH-1:0]  sum_q;
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] flags_q;
    logic              c_msb;
    logic              term;

    // First level: one lookahead slice per 4-bit group
    for (genvar k = 0; k < NG; k++) begin : g_slice
        cla_cla4 u_cla4 (
            .a     (iX[k*GROUP_W +: GROUP_W]),
            .b     (iY[k*GROUP_W +: GROUP_W]),
            .cin   (grp_c[k]),
            .s     (sum_d[k*GROUP_W +: GROUP_W]),
            .g_grp (grp_g[k]),
            .p_grp (grp_p[k])
        );
    end

    // Second level: each group carry as a flat sum of products over group G/P
    always_comb begin
        grp_c    = '0;
        term     = 1'b0;
        grp_c[0] = iCarry;
        for (int k = 1; k <= int'(NG); k++) begin
            for (int j = 0; j < k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & grp_p[m];
                end
                grp_c[k] = grp_c[k] | term;
            end
            term = iCarry;
            for (int m = 0; m < k; m++) begin
                term = term & grp_p[m];
            end
            grp_c[k] = grp_c[k] | term;
        end
    end

    // Condition flags; carry into the MSB recovered from its sum bit
    always_comb begin
        flags_d                = '0;
        c_msb                  = iX[WIDTH-1] ^ iY[WIDTH-1] ^ sum_d[WIDTH-1];
        flags_d[FLAG_CARRY]    = grp_c[NG];
        flags_d[FLAG_OVERFLOW] = grp_c[NG] ^ c_msb;
        flags_d[FLAG_ZERO]     = ~|sum_d;
        flags_d[FLAG_NEGATIVE] = sum_d[WIDTH-1];
    end

    // Output register; reset state matches the flags of a zero result
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sum_q              <= '0;
            flags_q            <= '0;
            flags_q[FLAG_ZERO] <= 1'b1;
        end else begin
            sum_q   <= sum_d;
            flags_q <= flags_d;
        end
    end

    // Select combinational or registered view (unused path trimmed in synthesis)
    always_comb begin
        if (REGISTERED != 0) begin
            oS        = sum_q;
            oCarry    = flags_q[FLAG_CARRY];
            oOverflow = flags_q[FLAG_OVERFLOW];
            oZero     = flags_q[FLAG_ZERO];
            oNegative = flags_q[FLAG_NEGATIVE];
        end else begin
            oS        = sum_d;
            oCarry    = flags_d[FLAG_CARRY];
            oOverflow = flags_d[FLAG_OVERFLOW];
            oZero     = flags_d[FLAG_ZERO];
            oNegative = flags_d[FLAG_NEGATIVE];
        end
    end

endmodule

// File: tb/tb_cla.sv
// Directed and random checks of the combinational and registered adder variants.
module tb_cla;

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;

    logic [31:0] s_c;
    logic        co_c, ov_c, z_c, n_c;
    logic [31:0] s_r;
    logic        co_r, ov_r, z_r, n_r;

    int errors = 0;
    int checks = 0;

    cla #(.WIDTH(32), .REGISTERED(0)) u_comb (
        .iClk      (clk),
        .iRst      (rst),
        .iX        (x),
        .iY        (y),
        .iCarry    (cin),
        .oS        (s_c),
        .oCarry    (co_c),
        .oOverflow (ov_c),
        .oZero     (z_c),
        .oNegative (n_c)
    );

    cla #(.WIDTH(32), .REGISTERED(1)) u_reg (
        .iClk      (clk),
        .iRst      (rst),
        .iX        (x),
        .iY        (y),
        .iCarry    (cin),
        .oS        (s_r),
        .oCarry    (co_r),
        .oOverflow (ov_r),
        .oZero     (z_r),
        .oNegative (n_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {carry, overflow, zero, negative}
    task automatic check_comb(input string tag, input logic [31:0] es, input logic [3:0] ef);
        check({tag, ".sum"}, s_c, es);
        check({tag, ".flags"}, 32'({co_c, ov_c, z_c, n_c}), 32'(ef));
    endtask

    task automatic check_reg(input string tag, input logic [31:0] es, input logic [3:0] ef);
        check({tag, ".sum"}, s_r, es);
        check({tag, ".flags"}, 32'({co_r, ov_r, z_r, n_r}), 32'(ef));
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic c);
        x   = a;
        y   = b;
        cin = c;
        #1;
    endtask

    logic [32:0] ref_full;
    logic [31:0] ref_s;
    logic [3:0]  ref_f;

    initial begin
        rst = 1'b1;
        x   = '0;
        y   = '0;
        cin = 1'b0;

        // Registered variant: reset held for two edges
        @(posedge clk);
        @(posedge clk); #1;
        check_reg("reg_reset", 32'h0, 4'b0010);

        rst = 1'b0;
        x = 32'd5; y = 32'd10; cin = 1'b0;
        #1;
        check_reg("reg_before_edge", 32'h0, 4'b0010);
        @(posedge clk); #1;
        check_reg("reg_5p10", 32'd15, 4'b0000);

        x = 32'd1; y = 32'd7;
        @(posedge clk); #1;
        check_reg("reg_1p7", 32'd8, 4'b0000);

        // Reset wins over the operation sampled on the same edge
        rst = 1'b1;
        x = 32'hFFFF_FFFF; y = 32'h0000_0002;
        @(posedge clk); #1;
        check_reg("reg_mid_reset", 32'h0, 4'b0010);

        rst = 1'b0;
        x = 32'd400; y = 32'd33;
        @(posedge clk); #1;
        check_reg("reg_400p33", 32'd433, 4'b0000);

        x = 32'h7FFF_FFFF; y = 32'h1;
        @(posedge clk); #1;
        check_reg("reg_ovf", 32'h8000_0000, 4'b0101);

        // Combinational directed vectors
        apply(32'd5, 32'd10, 1'b0);
        check_comb("add_5_10", 32'd15, 4'b0000);
        apply(32'd1, 32'd7, 1'b0);
        check_comb("add_1_7", 32'd8, 4'b0000);
        apply(32'd400, 32'd33, 1'b0);
        check_comb("add_400_33", 32'd433, 4'b0000);
        apply(32'hFFFF_FFFF, 32'h1, 1'b0);
        check_comb("wrap", 32'h0, 4'b1010);
        apply(32'h7FFF_FFFF, 32'h1, 1'b0);
        check_comb("pos_ovf", 32'h8000_0000, 4'b0101);
        apply(32'h8000_0000, 32'h8000_0000, 1'b0);
        check_comb("neg_ovf", 32'h0, 4'b1110);
        apply(32'h0, 32'h0, 1'b1);
        check_comb("cin_only", 32'h1, 4'b0000);
        apply(32'd10, ~32'd3, 1'b1);
        check_comb("sub_10_3", 32'd7, 4'b1000);
        apply(32'd3, ~32'd10, 1'b1);
        check_comb("sub_3_10", 32'hFFFF_FFF9, 4'b0001);
        apply(32'h0000_000F, 32'h0000_0001, 1'b0);
        check_comb("group_carry", 32'h0000_0010, 4'b0000);
        apply(32'h0FFF_FFFF, 32'h0000_0000, 1'b1);
        check_comb("long_propagate", 32'h1000_0000, 4'b0000);
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check_comb("all_ones_cin", 32'hFFFF_FFFF, 4'b1001);

        // Random vectors against a wide-add reference with sign-rule overflow
        for (int i = 0; i < 10000; i++) begin
            apply($urandom, $urandom, 1'($urandom_range(1, 0)));
            ref_full = 33'(x) + 33'(y) + 33'(cin);
            ref_s    = ref_full[31:0];
            ref_f[3] = ref_full[32];
            ref_f[2] = (x[31] == y[31]) && (ref_s[31] != x[31]);
            ref_f[1] = (ref_s == 32'h0);
            ref_f[0] = ref_s[31];
            check_comb("random", ref_s, ref_f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
